// File: rtl/mem_periph_slave.sv
// Memory-mapped slave: word RAM, LED register, free-running cycle counter and
// error-capture register behind a single valid/ready port with optional wait states.
module mem_periph_slave #(
  parameter logic [31:0] RAM_BASE    = 32'h0000_1000,
  parameter int          RAM_WORDS   = 1024,
  parameter logic [31:0] PERIPH_BASE = 32'h0000_2000,
  parameter int          LED_W       = 16,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mem_valid,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic             mem_ready,
  output logic [31:0]      mem_rdata,
  output logic [LED_W-1:0] leds,
  output logic             err
);
  localparam int          AW         = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES  = 33'(RAM_WORDS) * 33'd4;
  localparam int          LED_BYTES  = LED_W / 8;
  localparam logic [31:0] FAULT_WORD = 32'hDEAD_BEEF;
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    wait_cnt;
  logic [31:0]   cycle_cnt;
  logic [31:0]   erra;

  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   cnt_acc;
  logic [31:0]   ram [RAM_WORDS];

  logic          accept;
  logic          do_write;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_cnt;
  logic [31:0]   ram_off;
  logic [AW-1:0] ram_idx;
  logic          aligned;
  logic          ram_hit;
  logic          led_hit;
  logic          cnt_hit;
  logic          erra_hit;
  logic          fault;
  logic [31:0]   rd_word;

  assign accept   = (state == S_IDLE) && mem_valid;
  assign do_write = (state == S_RESP) && (wstrb_q != 4'b0000);

  // In IDLE the live bus is decoded (zero-wait reads resolve on the accept edge);
  // afterwards only the latched copy of the request matters.
  assign cur_addr = (state == S_IDLE) ? mem_addr  : addr_q;
  assign cur_cnt  = (state == S_IDLE) ? cycle_cnt : cnt_acc;

  always_comb begin
    ram_off  = cur_addr - RAM_BASE;
    ram_idx  = ram_off[AW+1:2];
    aligned  = (cur_addr[1:0] == 2'b00);
    ram_hit  = aligned && (cur_addr >= RAM_BASE) && ({1'b0, ram_off} < RAM_BYTES);
    led_hit  = aligned && (cur_addr == PERIPH_BASE + 32'd4);
    cnt_hit  = aligned && (cur_addr == PERIPH_BASE + 32'd8);
    erra_hit = aligned && (cur_addr == PERIPH_BASE + 32'd12);
    fault    = !(ram_hit || led_hit || cnt_hit || erra_hit);
  end

  always_comb begin
    rd_word = FAULT_WORD;
    if (ram_hit)       rd_word = ram[ram_idx];
    else if (led_hit)  rd_word = 32'(leds);
    else if (cnt_hit)  rd_word = cur_cnt;
    else if (erra_hit) rd_word = erra;
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept)
        wait_cnt <= WAIT_LOAD;
      else if (state == S_WAIT && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (mem_valid) state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (wait_cnt == 4'd0) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_ready = (state == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      wstrb_q <= mem_wstrb;
      cnt_acc <= cycle_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && ram_hit)
      for (int b = 0; b < 4; b++)
        if (wstrb_q[b]) ram[ram_idx][8*b +: 8] <= wdata_q[8*b +: 8];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle_cnt <= 32'd0;
      mem_rdata <= 32'd0;
      leds      <= '0;
      err       <= 1'b0;
      erra      <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state_nxt == S_RESP)
        mem_rdata <= rd_word;
      if (do_write && led_hit)
        for (int i = 0; i < LED_BYTES; i++)
          if (wstrb_q[i]) leds[8*i +: 8] <= wdata_q[8*i +: 8];
      // Faults are judged on the latched address in the response cycle.
      if (state == S_RESP) begin
        if (fault) begin
          err  <= 1'b1;
          erra <= addr_q;
        end else if (do_write && erra_hit) begin
          err  <= 1'b0;
          erra <= 32'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_periph_slave.sv
// Scoreboard bench: two slaves (zero and three wait states) driven with directed
// transactions; a negedge monitor pops expected read data on every mem_ready.
module tb_mem_periph_slave;
  typedef struct {
    logic        chk;
    logic [31:0] data;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n [2];
  logic        valid [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic [15:0] leds  [2];
  logic        err   [2];

  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          errors = 0;
  int          lat = 0;
  logic [31:0] ticks0;

  mem_periph_slave dut0 (
    .clk(clk), .resetn(rst_n[0]), .mem_valid(valid[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_ready(ready[0]),
    .mem_rdata(rdata[0]), .leds(leds[0]), .err(err[0])
  );

  mem_periph_slave #(.WAIT_CYCLES(3)) dut1 (
    .clk(clk), .resetn(rst_n[1]), .mem_valid(valid[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_ready(ready[1]),
    .mem_rdata(rdata[1]), .leds(leds[1]), .err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count for dut0: posedges seen since reset release.
  always @(posedge clk) begin
    if (!rst_n[0]) ticks0 <= 32'd0;
    else           ticks0 <= ticks0 + 32'd1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int s);
    exp_t e;
    if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ready_dut%0d: got mem_ready with rdata %h, expected no response", s, rdata[s]);
      return;
    end
    if (s == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (e.chk) check(e.name, rdata[s], e.data);
  endtask

  always @(negedge clk) begin
    if (ready[0] === 1'b1) mon(0);
    if (ready[1] === 1'b1) mon(1);
  end

  task automatic push(input int s, input logic chk, input logic [31:0] d, input string nm);
    exp_t e;
    e.chk  = chk;
    e.data = d;
    e.name = nm;
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic wait_ready(input int s, input string nm);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ready[s] !== 1'b1 && lat < 40);
    if (ready[s] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no mem_ready after %0d cycles, expected within 40", nm, lat);
    end
    valid[s] = 1'b0;
  endtask

  task automatic txn(input int s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                     input logic chk, input logic [31:0] x, input string nm);
    push(s, chk, x, nm);
    addr[s]  = a;
    wdata[s] = d;
    wstrb[s] = st;
    valid[s] = 1'b1;
    wait_ready(s, nm);
  endtask

  task automatic wr(input int s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    txn(s, a, d, st, 1'b0, 32'h0, "wr");
  endtask

  task automatic rd(input int s, input logic [31:0] a, input logic [31:0] x, input string nm);
    txn(s, a, 32'h0, 4'h0, 1'b1, x, nm);
  endtask

  task automatic idle(input int s, input int n);
    valid[s] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      valid[i] = 1'b0;
      addr[i]  = 32'h0;
      wdata[i] = 32'h0;
      wstrb[i] = 4'h0;
    end
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, ready[0]}, 32'h0);
    check("rst_rdata", rdata[0], 32'h0);
    check("rst_leds", {16'h0, leds[0]}, 32'h0);
    check("rst_err", {31'b0, err[0]}, 32'h0);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Basic RAM write/read, single-cycle latency
    wr(0, 32'h1000, 32'hCAFE_BABE, 4'hF);
    check("lat_w0", 32'(lat), 32'd1);
    idle(0, 1);
    rd(0, 32'h1000, 32'hCAFE_BABE, "rd_1000");
    check("lat_r0", 32'(lat), 32'd1);

    // Byte merge
    wr(0, 32'h1004, 32'h1122_3344, 4'hF);
    wr(0, 32'h1004, 32'hAABB_CCDD, 4'b0101);
    rd(0, 32'h1004, 32'h11BB_33DD, "rd_merge");

    // LED register
    wr(0, 32'h2004, 32'h0000_A55A, 4'hF);
    idle(0, 1);
    check("leds_write", {16'h0, leds[0]}, 32'h0000_A55A);
    wr(0, 32'h2004, 32'hFFFF_FFFF, 4'b1100);
    idle(0, 1);
    check("leds_upper_strb", {16'h0, leds[0]}, 32'h0000_A55A);
    rd(0, 32'h2004, 32'h0000_A55A, "rd_leds");

    // RAM upper boundary, then faults
    wr(0, 32'h1FFC, 32'h0BAD_F00D, 4'hF);
    rd(0, 32'h1FFC, 32'h0BAD_F00D, "rd_last_word");
    idle(0, 1);
    check("err_clean", {31'b0, err[0]}, 32'h0);
    rd(0, 32'h3000, 32'hDEAD_BEEF, "rd_fault_3000");
    idle(0, 1);
    check("err_set", {31'b0, err[0]}, 32'h1);
    rd(0, 32'h200C, 32'h0000_3000, "erra_3000");
    rd(0, 32'h2000, 32'hDEAD_BEEF, "rd_fault_2000");
    rd(0, 32'h200C, 32'h0000_2000, "erra_2000");
    rd(0, 32'h0FFC, 32'hDEAD_BEEF, "rd_fault_below");
    wr(0, 32'h1002, 32'hFFFF_FFFF, 4'hF);
    rd(0, 32'h1000, 32'hCAFE_BABE, "rd_after_misaligned");
    rd(0, 32'h200C, 32'h0000_1002, "erra_1002");
    wr(0, 32'h200C, 32'h0000_0001, 4'hF);
    idle(0, 1);
    check("err_cleared", {31'b0, err[0]}, 32'h0);
    rd(0, 32'h200C, 32'h0, "erra_cleared");
    wr(0, 32'h2008, 32'h1234_5678, 4'hF);
    idle(0, 1);
    check("err_cnt_write", {31'b0, err[0]}, 32'h0);

    // Counter: absolute values imply the read-to-read difference
    rd(0, 32'h2008, ticks0, "cnt_a");
    idle(0, 6);
    rd(0, 32'h2008, ticks0, "cnt_b");
    idle(0, 1);
    force dut0.cycle_cnt = 32'hFFFF_FFFE;
    release dut0.cycle_cnt;
    rd(0, 32'h2008, 32'hFFFF_FFFE, "cnt_wrap_a");
    rd(0, 32'h2008, 32'h0000_0000, "cnt_wrap_b");
    idle(0, 1);

    // Three wait states: latency, spacing, pulse width
    wr(1, 32'h1000, 32'h1357_9BDF, 4'hF);
    check("lat_w3", 32'(lat), 32'd4);
    rd(1, 32'h1000, 32'h1357_9BDF, "rd_w3_a");
    check("spacing_a", 32'(lat), 32'd5);
    rd(1, 32'h1000, 32'h1357_9BDF, "rd_w3_b");
    check("spacing_b", 32'(lat), 32'd5);
    idle(1, 1);
    check("ready_width", {31'b0, ready[1]}, 32'h0);

    // Payload changed after accept must be ignored
    push(1, 1'b1, 32'h1357_9BDF, "rd_latched");
    addr[1]  = 32'h1000;
    wstrb[1] = 4'h0;
    valid[1] = 1'b1;
    @(negedge clk);
    addr[1]  = 32'h3000;
    wstrb[1] = 4'hF;
    wait_ready(1, "rd_latched");
    wstrb[1] = 4'h0;
    idle(1, 1);
    check("err_latched", {31'b0, err[1]}, 32'h0);

    // Reset during WAIT aborts the write
    wr(1, 32'h1008, 32'h5A5A_0001, 4'hF);
    wr(1, 32'h2004, 32'h0000_1234, 4'hF);
    rd(1, 32'h3000, 32'hDEAD_BEEF, "rd_fault_w3");
    idle(1, 1);
    check("leds_w3", {16'h0, leds[1]}, 32'h0000_1234);
    check("err_w3", {31'b0, err[1]}, 32'h1);
    addr[1]  = 32'h1008;
    wdata[1] = 32'hFFFF_FFFF;
    wstrb[1] = 4'hF;
    valid[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    check("midrst_ready", {31'b0, ready[1]}, 32'h0);
    check("midrst_rdata", rdata[1], 32'h0);
    check("midrst_leds", {16'h0, leds[1]}, 32'h0);
    check("midrst_err", {31'b0, err[1]}, 32'h0);
    valid[1] = 1'b0;
    wstrb[1] = 4'h0;
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b1;
    rd(1, 32'h1008, 32'h5A5A_0001, "rd_after_rst");
    check("lat_after_rst", 32'(lat), 32'd4);
    rd(1, 32'h200C, 32'h0, "erra_after_rst");

    idle(0, 2);
    check("queues_empty", 32'(q0.size() + q1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, expected finish");
    $fatal(1);
  end

endmodule
